// File: rtl/ahb_bus_decoder_mux_if.sv
// AHB-Lite decoder/mux bus bundle: master address phase, slave responses and the
// multiplexed response back to the master.
interface ahb_bus_decoder_mux_if #(
  parameter int unsigned NUM_SLAVES = 2
);
  logic [31:0]              haddr;
  logic [1:0]               htrans;
  logic                     hready;
  logic                     hresp;
  logic [31:0]              hrdata;
  logic [NUM_SLAVES-1:0]    hsel;
  logic [NUM_SLAVES-1:0]    s_hreadyout;
  logic [NUM_SLAVES-1:0]    s_hresp;
  logic [32*NUM_SLAVES-1:0] s_hrdata;

  // Bus master plus slaves: everything that feeds the decoder.
  modport master (
    output haddr, htrans, s_hreadyout, s_hresp, s_hrdata,
    input  hready, hresp, hrdata, hsel
  );

  // The decoder/mux itself.
  modport slave (
    input  haddr, htrans, s_hreadyout, s_hresp, s_hrdata,
    output hready, hresp, hrdata, hsel
  );
endinterface

// File: rtl/ahb_bus_decoder_mux.sv
// AHB-Lite address decoder and data-phase response mux with a built-in default
// slave that answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR.
module ahb_bus_decoder_mux #(
  parameter int unsigned                 NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_BASE = {32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_MASK = {32'hF000_0000, 32'hF000_0000}
) (
  input  logic                clk,
  input  logic                rst,
  ahb_bus_decoder_mux_if.slave bus,
  output logic [15:0]         err_count
);

  typedef enum logic [1:0] {StOk, StErr1, StErr2} state_e;

  localparam logic [NUM_SLAVES:0] DselDefault = {1'b1, {NUM_SLAVES{1'b0}}};

  state_e                state_q, state_d;
  logic [NUM_SLAVES:0]   dsel_q, dsel_d;
  logic [15:0]           err_count_q, err_count_d;
  logic [NUM_SLAVES-1:0] hit_sel;
  logic                  hit_any;
  logic                  hready, hresp;
  logic [31:0]           hrdata;
  logic                  fsm_hready, fsm_hresp;

  // Scan from the top down so the lowest matching index ends up selected.
  always_comb begin
    hit_sel = '0;
    hit_any = 1'b0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((bus.haddr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
        hit_any    = 1'b1;
      end
    end
  end

  assign fsm_hready = (state_q != StErr1);
  assign fsm_hresp  = (state_q != StOk);

  always_comb begin
    hready = 1'b0;
    hresp  = 1'b0;
    hrdata = '0;
    if (dsel_q[NUM_SLAVES]) begin
      hready = fsm_hready;
      hresp  = fsm_hresp;
    end else begin
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
        if (dsel_q[i]) begin
          hready = bus.s_hreadyout[i];
          hresp  = bus.s_hresp[i];
          hrdata = bus.s_hrdata[32*i +: 32];
        end
      end
    end
  end

  assign bus.hsel   = hit_sel;
  assign bus.hready = hready;
  assign bus.hresp  = hresp;
  assign bus.hrdata = hrdata;
  assign err_count  = err_count_q;

  always_comb begin
    state_d     = state_q;
    err_count_d = err_count_q;
    dsel_d      = hready ? {~hit_any, hit_sel} : dsel_q;
    case (state_q)
      StOk:    if (hready && bus.htrans[1] && !hit_any) state_d = StErr1;
      StErr1:  state_d = StErr2;
      // Second ERROR cycle is also an address-phase sample point.
      StErr2:  state_d = (bus.htrans[1] && !hit_any) ? StErr1 : StOk;
      default: state_d = StOk;
    endcase
    if (state_d == StErr1 && err_count_q != 16'hFFFF) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StOk;
      dsel_q      <= DselDefault;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      dsel_q      <= dsel_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_ahb_bus_decoder_mux.sv
// Scoreboard bench for ahb_bus_decoder_mux: stimulus queues expected data-phase
// responses, a negedge monitor pops and compares them as data phases complete.
module tb_ahb_bus_decoder_mux;

  typedef struct packed {
    logic [31:0] rdata;
    logic        resp;
    logic [7:0]  waits;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [15:0] err_count;
  logic       tr_valid;
  logic       dp_valid;
  logic [3:0] stall_next;
  logic [3:0] stall_cnt;
  logic [7:0] mon_waits;
  exp_t       exp_q[$];
  int         n_checks;
  int         n_fail;

  ahb_bus_decoder_mux_if #(.NUM_SLAVES(2)) bus ();

  ahb_bus_decoder_mux #(.NUM_SLAVES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave models: fixed read data, slave 0 can be stalled for a programmed count.
  assign bus.s_hrdata    = {32'hDEAD_BEEF, 32'hA5A5_0000};
  assign bus.s_hresp     = 2'b00;
  assign bus.s_hreadyout = {1'b1, stall_cnt == 4'd0};

  always @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      dp_valid  <= 1'b0;
    end else if (bus.hready) begin
      stall_cnt <= stall_next;
      dp_valid  <= tr_valid;
    end else if (stall_cnt != 4'd0) begin
      stall_cnt <= stall_cnt - 4'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every data-phase cycle against the oldest queued entry.
  always @(negedge clk) begin
    if (rst) begin
      mon_waits <= '0;
    end else if (dp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dphase", 32'd1, 32'd0);
      end else if (!bus.hready) begin
        mon_waits <= mon_waits + 8'd1;
        chk("wait_hresp", {31'd0, bus.hresp}, {31'd0, exp_q[0].resp});
        chk("wait_hrdata", bus.hrdata, exp_q[0].rdata);
      end else begin
        chk("hrdata", bus.hrdata, exp_q[0].rdata);
        chk("hresp", {31'd0, bus.hresp}, {31'd0, exp_q[0].resp});
        chk("wait_states", {24'd0, mon_waits}, {24'd0, exp_q[0].waits});
        exp_q.delete(0);
        mon_waits <= '0;
      end
    end
  end

  // Called at posedge+1; drives one address phase and returns once it is accepted.
  task automatic issue(input logic [31:0] a, input logic [1:0] t, input logic track,
                       input logic [31:0] rdata, input logic resp, input int waits,
                       input logic [1:0] exp_hsel, input int stall);
    exp_t e;
    int   n;
    logic ok;
    bus.haddr  = a;
    bus.htrans = t;
    tr_valid   = track;
    stall_next = stall[3:0];
    #1;
    chk("hsel", {30'd0, bus.hsel}, {30'd0, exp_hsel});
    if (track) begin
      e.rdata = rdata;
      e.resp  = resp;
      e.waits = waits[7:0];
      exp_q.push_back(e);
    end
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bus.hready;
      n++;
      if (!ok) begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) chk("addr_phase_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    tr_valid   = 1'b0;
    bus.htrans = 2'b00;
    stall_next = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.haddr  = '0;
    bus.htrans = 2'b00;
    tr_valid   = 1'b0;
    stall_next = '0;

    // Reset
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_hready", {31'd0, bus.hready}, 32'd1);
    chk("rst_hresp", {31'd0, bus.hresp}, 32'd0);
    chk("rst_hrdata", bus.hrdata, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_hready", {31'd0, bus.hready}, 32'd1);
    @(posedge clk); #1;

    // Read from slave 1
    issue(32'h1000_0004, 2'b10, 1'b1, 32'hDEAD_BEEF, 1'b0, 0, 2'b10, 0);
    // Slave 0 stalls 3 cycles while the next address (slave 1) is presented
    issue(32'h0000_0010, 2'b10, 1'b1, 32'hA5A5_0000, 1'b0, 3, 2'b01, 3);
    issue(32'h1000_0000, 2'b10, 1'b1, 32'hDEAD_BEEF, 1'b0, 0, 2'b10, 0);
    // Unmapped NONSEQ, followed by an IDLE to slave 0
    issue(32'h5000_0000, 2'b10, 1'b1, 32'h0, 1'b1, 1, 2'b00, 0);
    issue(32'h0000_0000, 2'b00, 1'b1, 32'hA5A5_0000, 1'b0, 0, 2'b01, 0);
    issue(32'h0000_0000, 2'b00, 1'b0, 32'h0, 1'b0, 0, 2'b01, 0);
    chk("err_count_one", {16'd0, err_count}, 32'd1);

    // Back-to-back unmapped errors, then an unmapped IDLE
    do_reset();
    issue(32'h5000_0000, 2'b10, 1'b1, 32'h0, 1'b1, 1, 2'b00, 0);
    issue(32'h6000_0000, 2'b11, 1'b1, 32'h0, 1'b1, 1, 2'b00, 0);
    issue(32'h7000_0000, 2'b00, 1'b1, 32'h0, 1'b0, 0, 2'b00, 0);
    issue(32'h0000_0000, 2'b00, 1'b0, 32'h0, 1'b0, 0, 2'b01, 0);
    chk("err_count_two", {16'd0, err_count}, 32'd2);

    // Reset while in ERR1
    bus.haddr  = 32'h5000_0000;
    bus.htrans = 2'b10;
    tr_valid   = 1'b0;
    @(posedge clk); #1;
    bus.htrans = 2'b00;
    rst        = 1'b1;
    @(negedge clk);
    chk("err1_hready", {31'd0, bus.hready}, 32'd0);
    chk("err1_hresp", {31'd0, bus.hresp}, 32'd1);
    chk("err1_err_count", {16'd0, err_count}, 32'd3);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_err1_hready", {31'd0, bus.hready}, 32'd1);
    chk("rst_err1_hresp", {31'd0, bus.hresp}, 32'd0);
    chk("rst_err1_hrdata", bus.hrdata, 32'd0);
    chk("rst_err1_err_count", {16'd0, err_count}, 32'd0);
    @(posedge clk); #1;

    // Normal traffic resumes after reset
    issue(32'h1000_0008, 2'b10, 1'b1, 32'hDEAD_BEEF, 1'b0, 0, 2'b10, 0);
    issue(32'h0000_0000, 2'b00, 1'b0, 32'h0, 1'b0, 0, 2'b01, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    summary();
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $finish;
  end

endmodule
